// File: rtl/fifo_pkg.sv
// fifo_pkg: shared defaults and level-width helper for sync_fifo_mc and its bench
package fifo_pkg;
    localparam int DWIDTH_DEF    = 16;
    localparam int AWIDTH_DEF    = 5;
    localparam int NCH_DEF       = 2;
    localparam int AEMPTY_TH_DEF = 2;

    function automatic int lvl_w(input int aw);
        return aw + 1;
    endfunction

    function automatic int afull_def(input int aw);
        return (1 << aw) - 2;
    endfunction

    localparam int AFULL_TH_DEF = afull_def(AWIDTH_DEF);
endpackage

// File: rtl/sync_fifo_ch.sv
// sync_fifo_ch: single-channel FIFO with registered read data, level and flags
// Sticky ovf/udf ports exist only when FIFO_ERR_STICKY_EN is defined.
module sync_fifo_ch import fifo_pkg::*; #(
    parameter int DWIDTH    = DWIDTH_DEF,
    parameter int AWIDTH    = AWIDTH_DEF,
    parameter int AFULL_TH  = AFULL_TH_DEF,
    parameter int AEMPTY_TH = AEMPTY_TH_DEF
) (
    input  logic              clk,
    input  logic              srst,
    input  logic              wdv,
    input  logic [DWIDTH-1:0] wdata,
    output logic              wfull,
    output logic              wafull,
    input  logic              rrq,
    output logic              rdv,
    output logic [DWIDTH-1:0] rdata,
    output logic              rempty,
    output logic              raempty,
`ifdef FIFO_ERR_STICKY_EN
    output logic              ovf,
    output logic              udf,
`endif
    output logic [AWIDTH:0]   level
);
    localparam int DEPTH = 1 << AWIDTH;
    localparam int LW    = lvl_w(AWIDTH);

    logic [DWIDTH-1:0] mem [DEPTH];
    logic [AWIDTH:0]   wp, rp, lv;
    logic              wa, ra;

    assign wa = wdv & ~wfull;
    assign ra = rrq & ~rempty;
    // flags are registered from the next level; reset forces the level-0 view
    assign lv = srst ? '0 : level + LW'(wa) - LW'(ra);

    always_ff @(posedge clk)
        if (wa && !srst) mem[wp[AWIDTH-1:0]] <= wdata;

    always_ff @(posedge clk) begin
        if (srst) begin
            wp    <= '0;
            rp    <= '0;
            rdv   <= 1'b0;
            rdata <= '0;
        end else begin
            if (wa) wp <= wp + 1'b1;
            if (ra) begin
                rp    <= rp + 1'b1;
                rdata <= mem[rp[AWIDTH-1:0]];
            end
            rdv <= ra;
        end
        level   <= lv;
        wfull   <= lv == LW'(DEPTH);
        rempty  <= lv == '0;
        wafull  <= int'(lv) >= AFULL_TH;
        raempty <= int'(lv) <= AEMPTY_TH;
    end

`ifdef FIFO_ERR_STICKY_EN
    always_ff @(posedge clk) begin
        if (srst) begin
            ovf <= 1'b0;
            udf <= 1'b0;
        end else begin
            ovf <= ovf | (wdv & wfull);
            udf <= udf | (rrq & rempty);
        end
    end
`endif
endmodule

// File: rtl/sync_fifo_mc.sv
// sync_fifo_mc: NCH independent single-clock FIFOs sharing one set of packed ports
// Sticky ovf/udf ports exist only when FIFO_ERR_STICKY_EN is defined.
module sync_fifo_mc import fifo_pkg::*; #(
    parameter int DWIDTH    = DWIDTH_DEF,
    parameter int AWIDTH    = AWIDTH_DEF,
    parameter int NCH       = NCH_DEF,
    parameter int AFULL_TH  = (1 << AWIDTH) - 2,
    parameter int AEMPTY_TH = AEMPTY_TH_DEF
) (
    input  logic                          clk,
    input  logic                          srst,
    input  logic [NCH-1:0]                wdv,
    input  logic [NCH*DWIDTH-1:0]         wdata,
    output logic [NCH-1:0]                wfull,
    output logic [NCH-1:0]                wafull,
    input  logic [NCH-1:0]                rrq,
    output logic [NCH-1:0]                rdv,
    output logic [NCH*DWIDTH-1:0]         rdata,
    output logic [NCH-1:0]                rempty,
    output logic [NCH-1:0]                raempty,
`ifdef FIFO_ERR_STICKY_EN
    output logic [NCH-1:0]                ovf,
    output logic [NCH-1:0]                udf,
`endif
    output logic [NCH*lvl_w(AWIDTH)-1:0] level
);
    localparam int DEPTH = 1 << AWIDTH;
    localparam int LW    = lvl_w(AWIDTH);

    if (NCH < 1 || NCH > 8) begin : g_nch_chk
        $error("sync_fifo_mc: NCH must be 1..8");
    end
    if (!(AEMPTY_TH < AFULL_TH && AFULL_TH <= DEPTH)) begin : g_th_chk
        $error("sync_fifo_mc: need AEMPTY_TH < AFULL_TH <= DEPTH");
    end

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        sync_fifo_ch #(
            .DWIDTH(DWIDTH), .AWIDTH(AWIDTH), .AFULL_TH(AFULL_TH), .AEMPTY_TH(AEMPTY_TH)
        ) u_ch (
            .clk    (clk),
            .srst   (srst),
            .wdv    (wdv[c]),
            .wdata  (wdata[c*DWIDTH +: DWIDTH]),
            .wfull  (wfull[c]),
            .wafull (wafull[c]),
            .rrq    (rrq[c]),
            .rdv    (rdv[c]),
            .rdata  (rdata[c*DWIDTH +: DWIDTH]),
            .rempty (rempty[c]),
            .raempty(raempty[c]),
`ifdef FIFO_ERR_STICKY_EN
            .ovf    (ovf[c]),
            .udf    (udf[c]),
`endif
            .level  (level[c*LW +: LW])
        );
    end
endmodule
